reg_file_dump: RTL and testbench

REG_FILE_DUMP -- requirements
Module: reg_file_dump

---
 rtl/riscv_pkg.sv | 15 +
 rtl/reg_file_dump_if.sv | 33 +++
 rtl/reg_file_dump.sv | 81 ++++++++
 tb/tb_reg_file_dump.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the register-file dump engine: state encoding and
// the default address/data widths of the register file it reads.
package riscv_pkg;

  localparam int default_address_width = 5;
  localparam int default_register_size = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/reg_file_dump_if.sv
// Control, register-file read port and output stream of the dump engine.
// The engine itself connects through the slave modport.
interface reg_file_dump_if
  import riscv_pkg::*;
#(
  parameter int address_width = default_address_width,
  parameter int register_size = default_register_size
);

  logic                     start_i;
  logic                     abort_i;
  logic [address_width-1:0] first_addr_i;
  logic [address_width-1:0] last_addr_i;
  logic [address_width-1:0] rf_addr_o;
  logic [register_size-1:0] rf_data_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [address_width-1:0] out_addr_o;
  logic [register_size-1:0] out_data_o;
  logic                     busy_o;
  logic                     done_o;

  modport slave (
    input  start_i, abort_i, first_addr_i, last_addr_i, rf_data_i, out_ready_i,
    output rf_addr_o, out_valid_o, out_addr_o, out_data_o, busy_o, done_o
  );

  modport master (
    output start_i, abort_i, first_addr_i, last_addr_i, rf_data_i, out_ready_i,
    input  rf_addr_o, out_valid_o, out_addr_o, out_data_o, busy_o, done_o
  );

endinterface

// File: rtl/reg_file_dump.sv
// Register-file dump engine: walks first..last (wrapping past the top address)
// through a combinational read port and streams each word over valid/ready.
module reg_file_dump
  import riscv_pkg::*;
#(
  parameter int address_width = default_address_width,
  parameter int register_size = default_register_size
) (
  input logic            clk,
  input logic            reset,
  reg_file_dump_if.slave bus
);

  // state | meaning
  // IDLE  | waiting for start_i, read address parked at 0
  // READ  | read port addresses current register, word captured into output register
  // SEND  | word presented, held until out_ready_i
  // DONE  | single-cycle done_o pulse

  dump_state_t state, state_nxt;

  logic [address_width-1:0] cur_addr;
  logic [address_width-1:0] last_addr;
  logic [address_width-1:0] out_addr;
  logic [register_size-1:0] out_data;
  logic                     handshake;
  logic                     at_last;

  assign handshake = (state == SEND) && bus.out_ready_i;
  assign at_last   = (cur_addr == last_addr);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start_i) state_nxt = READ;
      READ:    state_nxt = SEND;
      SEND:    if (handshake) state_nxt = at_last ? DONE : READ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // abort wins over a same-cycle handshake; the accepted word still counts
    if (state != IDLE && bus.abort_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_addr  <= '0;
      last_addr <= '0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            cur_addr  <= bus.first_addr_i;
            last_addr <= bus.last_addr_i;
          end
        end
        READ: begin
          out_addr <= cur_addr;
          out_data <= bus.rf_data_i;
        end
        SEND: begin
          // natural overflow gives the wrap from the top register back to 0
          if (handshake && !at_last) cur_addr <= cur_addr + address_width'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.rf_addr_o   = (state == IDLE) ? '0 : cur_addr;
  assign bus.out_valid_o = (state == SEND);
  assign bus.out_addr_o  = out_addr;
  assign bus.out_data_o  = out_data;
  assign bus.busy_o      = (state != IDLE);
  assign bus.done_o      = (state == DONE);

endmodule

// File: tb/tb_reg_file_dump.sv
// Bench for reg_file_dump: register-file model with write-back bypass, a queue
// of expected words built from first/last, and a monitor that checks every word.
module tb_reg_file_dump;
  import riscv_pkg::*;

  localparam int aw    = default_address_width;
  localparam int rs    = default_register_size;
  localparam int nregs = 1 << aw;

  typedef struct {
    logic [aw-1:0] addr;
    logic [rs-1:0] data;
  } word_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int cyc         = 0;
  int n_checks    = 0;
  int n_fail      = 0;
  int done_cnt    = 0;
  int exp_done    = 0;
  int start_cyc   = 0;
  int last_hs_cyc = -10;
  int ready_mode  = 0;
  int stall_cnt   = 0;
  bit gap_check    = 1'b0;
  bit bypass_arm   = 1'b0;
  bit bypass_fired = 1'b0;
  bit loaded       = 1'b0;

  logic          we    = 1'b0;
  logic [aw-1:0] waddr = '0;
  logic [rs-1:0] wdata = '0;
  logic [rs-1:0] rf_mem     [nregs];
  logic [rs-1:0] model_regs [nregs];
  word_t exp_q [$];

  reg_file_dump_if #(.address_width(aw), .register_size(rs)) bus ();

  reg_file_dump #(.address_width(aw), .register_size(rs)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // register file: synchronous write, combinational read with write-back bypass
  always @(posedge clk) if (we) rf_mem[waddr] <= wdata;
  assign bus.rf_data_i = (we && waddr == bus.rf_addr_o) ? wdata : rf_mem[bus.rf_addr_o];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_dump(input int first, input int last);
    int a;
    word_t w;
    a = first;
    forever begin
      w.addr = aw'(a);
      w.data = model_regs[a];
      exp_q.push_back(w);
      if (a == last) break;
      a = (a + 1) % nregs;
    end
  endtask

  task automatic do_start(input int first, input int last);
    @(posedge clk); #1;
    bus.first_addr_i = aw'(first);
    bus.last_addr_i  = aw'(last);
    bus.start_i      = 1'b1;
    start_cyc        = cyc;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cnt >= exp_done) break;
    end
    @(negedge clk); #1;
    check("done_count", done_cnt, exp_done);
    check("queue_drained", exp_q.size(), 0);
    check("idle_after_done", bus.busy_o, 0);
  endtask

  task automatic run_dump(input int first, input int last, input int budget);
    push_dump(first, last);
    exp_done++;
    do_start(first, last);
    wait_done(budget);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, bus.out_valid_o, 0);
    check({tag, "_busy"},      bus.busy_o, 0);
    check({tag, "_done"},      bus.done_o, 0);
    check({tag, "_out_addr"},  bus.out_addr_o, 0);
    check({tag, "_out_data"},  bus.out_data_o, 0);
    check({tag, "_rf_addr"},   bus.rf_addr_o, 0);
  endtask

  // environment: loads the register file, then drives out_ready and the bypass write
  initial begin
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < nregs; i++) begin
      @(posedge clk); #1;
      we    = 1'b1;
      waddr = aw'(i);
      wdata = rs'(32'h100 + i);
    end
    @(posedge clk); #1;
    we     = 1'b0;
    loaded = 1'b1;
    forever begin
      @(posedge clk); #1;
      we = 1'b0;
      case (ready_mode)
        1: bus.out_ready_i = 1'($urandom_range(0, 1));
        2: begin
          if (bus.out_valid_o && bus.out_addr_o == aw'(3) && stall_cnt < 5) begin
            bus.out_ready_i = 1'b0;
            stall_cnt++;
          end else begin
            bus.out_ready_i = 1'b1;
          end
        end
        default: bus.out_ready_i = 1'b1;
      endcase
      if (ready_mode != 2) stall_cnt = 0;
      if (bypass_arm && !bypass_fired && bus.busy_o && !bus.out_valid_o && !bus.done_o &&
          bus.rf_addr_o == aw'(5)) begin
        we           = 1'b1;
        waddr        = aw'(5);
        wdata        = 32'hDEAD_BEEF;
        bypass_fired = 1'b1;
      end
    end
  end

  // monitor: pops the scoreboard on every accepted word
  initial begin
    bit            hold;
    logic [aw-1:0] hold_addr;
    logic [rs-1:0] hold_data;
    word_t         w;
    hold = 1'b0;
    hold_addr = '0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (hold) begin
          check("stall_valid_held", bus.out_valid_o, 1);
          check("stall_addr_stable", bus.out_addr_o, hold_addr);
          check("stall_data_stable", bus.out_data_o, hold_data);
        end
        if (bus.out_valid_o && bus.out_ready_i) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got addr %0d data %08h, expected no word", bus.out_addr_o, bus.out_data_o);
          end else begin
            w = exp_q.pop_front();
            check("word_addr", bus.out_addr_o, w.addr);
            check("word_data", bus.out_data_o, w.data);
          end
          if (gap_check) begin
            if (last_hs_cyc < start_cyc) check("first_word_latency", cyc - start_cyc, 2);
            else                         check("word_spacing", cyc - last_hs_cyc, 2);
          end
          last_hs_cyc = cyc;
        end
        if (bus.done_o) begin
          done_cnt++;
          check("done_after_last_word", exp_q.size(), 0);
        end
      end
      hold      = !reset && !bus.abort_i && bus.out_valid_o && !bus.out_ready_i;
      hold_addr = bus.out_addr_o;
      hold_data = bus.out_data_o;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bus.start_i      = 1'b0;
    bus.abort_i      = 1'b0;
    bus.first_addr_i = '0;
    bus.last_addr_i  = '0;
    for (int i = 0; i < nregs; i++) model_regs[i] = rs'(32'h100 + i);
    for (int i = 0; i < 2000 && !loaded; i++) @(posedge clk);
    @(posedge clk); #1;
    check_all_zero("reset");
    reset = 1'b0;

    // full ascending dump, wrap-around dump
    ready_mode = 0;
    gap_check  = 1'b1;
    run_dump(0, 31, 200);
    run_dump(30, 1, 100);

    // consumer stall on word 3
    ready_mode = 2;
    gap_check  = 1'b0;
    run_dump(0, 7, 200);
    check("stall_cycles", stall_cnt, 5);

    // write to r5 in the very cycle READ addresses it
    ready_mode    = 0;
    gap_check     = 1'b1;
    model_regs[5] = 32'hDEAD_BEEF;
    bypass_arm    = 1'b1;
    run_dump(3, 7, 100);
    check("bypass_fired", bypass_fired, 1);
    bypass_arm = 1'b0;

    run_dump(17, 17, 50);

    // random ranges under random backpressure
    ready_mode = 1;
    gap_check  = 1'b0;
    repeat (6) run_dump(int'($urandom_range(0, nregs - 1)), int'($urandom_range(0, nregs - 1)), 800);
    run_dump(31, 31, 100);

    // abort mid-dump
    ready_mode = 0;
    gap_check  = 1'b1;
    push_dump(0, 31);
    do_start(0, 31);
    repeat ($urandom_range(4, 30)) @(posedge clk);
    #1 bus.abort_i = 1'b1;
    @(posedge clk); #1;
    bus.abort_i = 1'b0;
    check("abort_busy", bus.busy_o, 0);
    check("abort_out_valid", bus.out_valid_o, 0);
    check("abort_done", bus.done_o, 0);
    check("abort_rf_addr", bus.rf_addr_o, 0);
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1 check("no_done_after_abort", done_cnt, exp_done);

    // start pulse while busy must be ignored
    push_dump(10, 13);
    exp_done++;
    do_start(10, 13);
    repeat (2) @(posedge clk);
    #1;
    bus.first_addr_i = '0;
    bus.last_addr_i  = aw'(31);
    bus.start_i      = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    wait_done(100);

    // reset mid-dump, together with start and abort
    push_dump(0, 31);
    do_start(0, 31);
    repeat ($urandom_range(5, 30)) @(posedge clk);
    #1;
    reset            = 1'b1;
    bus.start_i      = 1'b1;
    bus.abort_i      = 1'b1;
    bus.first_addr_i = aw'(7);
    @(posedge clk); #1;
    check_all_zero("midreset");
    reset       = 1'b0;
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check("idle_after_reset_release", bus.busy_o, 0);
    check("no_done_after_reset", done_cnt, exp_done);

    run_dump(28, 3, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
